// File: rtl/ysyx_23060061_pkg.sv
// Shared response codes, channel FSM encodings and the default memory window
// for the ysyx_23060061 AXI-lite SRAM model.
package ysyx_23060061_pkg;

  localparam logic [1:0]  RESP_OKAY         = 2'b00;
  localparam logic [1:0]  RESP_SLVERR       = 2'b10;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_t;

  // Window test done in 33 bits so a window ending at 4 GiB cannot wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [32:0] limit);
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/ysyx_23060061_delay_cnt.sv
// Loadable 4-bit down counter; o_done is high for the single cycle in which
// the count is 1, so a load of N gives done N edges after the load edge.
module ysyx_23060061_delay_cnt (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_value,
  output logic       o_done
);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_done = (r_cnt == 4'd1);

endmodule

// File: rtl/ysyx_23060061_sram.sv
// AXI-lite word SRAM with independent read and write channels, programmable
// response latency, byte strobes and SLVERR outside the mapped window.
module ysyx_23060061_sram
  import ysyx_23060061_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDXW  = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;

  logic [31:0] r_mem [DEPTH];

  logic        r_live;
  rd_state_t   r_rstate, w_rd_next;
  wr_state_t   r_wstate, w_wr_next;
  logic [31:0] r_araddr, r_awaddr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_got, r_w_got;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp, r_bresp;

  logic            w_ar_hs, w_aw_hs, w_w_hs;
  logic            w_rd_load, w_wr_load, w_rd_done, w_wr_done;
  logic            w_rd_sample, w_wr_commit;
  logic            w_rd_ok, w_wr_ok;
  logic [IDXW-1:0] w_rd_idx, w_wr_idx;

  // r_live keeps every ready low for the cycles in which reset was sampled.
  always_ff @(posedge clk) begin
    if (!rst) r_live <= 1'b0;
    else      r_live <= 1'b1;
  end

  assign arready = r_live && (r_rstate == R_IDLE);
  assign awready = r_live && (r_wstate == W_IDLE) && !r_aw_got;
  assign wready  = r_live && (r_wstate == W_IDLE) && !r_w_got;
  assign rvalid  = (r_rstate == R_RESP);
  assign bvalid  = (r_wstate == W_RESP);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign bresp   = r_bresp;

  assign w_ar_hs = arvalid && arready;
  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;

  assign w_rd_ok  = in_window(r_araddr, BASE_ADDR, LIMIT);
  assign w_wr_ok  = in_window(r_awaddr, BASE_ADDR, LIMIT);
  assign w_rd_idx = IDXW'((r_araddr - BASE_ADDR) >> 2);
  assign w_wr_idx = IDXW'((r_awaddr - BASE_ADDR) >> 2);

  assign w_rd_sample = (r_rstate == R_WAIT) && w_rd_done;
  assign w_wr_commit = rst && (r_wstate == W_WAIT) && w_wr_done;

  ysyx_23060061_delay_cnt u_rd_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_load  (w_rd_load),
    .i_value (4'(READ_LAT)),
    .o_done  (w_rd_done)
  );

  ysyx_23060061_delay_cnt u_wr_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_load  (w_wr_load),
    .i_value (4'(WRITE_LAT)),
    .o_done  (w_wr_done)
  );

  always_comb begin
    w_rd_next = r_rstate;
    w_rd_load = 1'b0;
    unique case (r_rstate)
      R_IDLE: if (w_ar_hs) begin
        w_rd_next = R_WAIT;
        w_rd_load = 1'b1;
      end
      R_WAIT: if (w_rd_done) w_rd_next = R_RESP;
      R_RESP: if (rready) w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rstate <= R_IDLE;
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      r_rstate <= w_rd_next;
      if (w_ar_hs) r_araddr <= araddr;
      if (w_rd_sample) begin
        r_rdata <= w_rd_ok ? r_mem[w_rd_idx] : '0;
        r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // AW and W may arrive in either order; the later one starts the latency.
  always_comb begin
    w_wr_next = r_wstate;
    w_wr_load = 1'b0;
    unique case (r_wstate)
      W_IDLE: if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) begin
        w_wr_next = W_WAIT;
        w_wr_load = 1'b1;
      end
      W_WAIT: if (w_wr_done) w_wr_next = W_RESP;
      W_RESP: if (bready) w_wr_next = W_IDLE;
      default: w_wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wstate <= W_IDLE;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
    end else begin
      r_wstate <= w_wr_next;
      if (w_aw_hs) begin
        r_aw_got <= 1'b1;
        r_awaddr <= awaddr;
      end
      if (w_w_hs) begin
        r_w_got <= 1'b1;
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if ((r_wstate == W_RESP) && bready) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
      end
      if (w_wr_commit) r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Storage has no reset; a same-edge read sample sees the pre-commit word.
  always_ff @(posedge clk) begin
    if (w_wr_commit && w_wr_ok) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_wstrb[i]) r_mem[w_wr_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_sram.sv
// Directed self-checking bench for ysyx_23060061_sram (READ_LAT=3, WRITE_LAT=2).
module tb_ysyx_23060061_sram;

  localparam int RL = 3;
  localparam int WL = 2;

  logic        clk, rst;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int total = 0;
  int bad   = 0;

  ysyx_23060061_sram #(
    .BASE_ADDR (32'h8000_0000),
    .DEPTH     (4096),
    .READ_LAT  (RL),
    .WRITE_LAT (WL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Starts at a negedge with the write channel idle; lat counts edges from the W capture.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic [1:0] resp);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 40) begin @(negedge clk); lat++; end
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 40) begin @(negedge clk); lat++; end
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(negedge clk);
    total++; if ({arready, awready, wready} !== 3'b000) begin bad++; $display("FAIL reset_readies got=%b exp=000", {arready, awready, wready}); end
    total++; if ({rvalid, bvalid} !== 2'b00) begin bad++; $display("FAIL reset_valids got=%b exp=00", {rvalid, bvalid}); end
    total++; if ({rdata, rresp, bresp} !== 36'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {rdata, rresp, bresp}); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({arready, awready, wready} !== 3'b111) begin bad++; $display("FAIL release_readies got=%b exp=111", {arready, awready, wready}); end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, lat, r);
    total++; if (r !== 2'b00) begin bad++; $display("FAIL wr_bresp got=%b exp=00", r); end
    total++; if (lat !== WL) begin bad++; $display("FAIL wr_latency got=%0d exp=%0d", lat, WL); end
    axi_read(32'h8000_0010, d, r, lat);
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", d); end
    total++; if (r !== 2'b00) begin bad++; $display("FAIL rd_rresp got=%b exp=00", r); end
    total++; if (lat !== RL) begin bad++; $display("FAIL rd_latency got=%0d exp=%0d", lat, RL); end
    total++; if ({rvalid, arready} !== 2'b01) begin bad++; $display("FAIL rd_return_idle got=%b exp=01", {rvalid, arready}); end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(32'h8000_0010, 32'h0000_0055, 4'b0001, lat, r);
    axi_read(32'h8000_0010, d, r, lat);
    total++; if (d !== 32'hDEAD_BE55) begin bad++; $display("FAIL strb_0001 got=%h exp=deadbe55", d); end
    axi_write(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, lat, r);
    total++; if (r !== 2'b00) begin bad++; $display("FAIL strb_0000_resp got=%b exp=00", r); end
    axi_read(32'h8000_0013, d, r, lat);
    total++; if (d !== 32'hDEAD_BE55) begin bad++; $display("FAIL strb_0000_unaligned got=%h exp=deadbe55", d); end
    axi_write(32'h8000_0012, 32'hAABB_0000, 4'b1100, lat, r);
    axi_read(32'h8000_0010, d, r, lat);
    total++; if (d !== 32'hAABB_BE55) begin bad++; $display("FAIL strb_1100 got=%h exp=aabbbe55", d); end
  endtask

  task automatic test_split_and_stall();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(32'h8000_0044, 32'h1234_5678, 4'b1111, lat, r);
    awaddr = 32'h8000_0040; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    total++; if ({awready, wready} !== 2'b01) begin bad++; $display("FAIL split_aw_drop got=%b exp=01", {awready, wready}); end
    repeat (2) @(negedge clk);
    wdata = 32'hCAFE_F00D; wstrb = 4'b1111; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    total++; if (wready !== 1'b0) begin bad++; $display("FAIL split_w_drop got=%b exp=0", wready); end
    lat = 0;
    while (!bvalid && lat < 40) begin @(negedge clk); lat++; end
    total++; if (3 + lat !== 3 + WL) begin bad++; $display("FAIL split_bvalid_edge got=T+%0d exp=T+%0d", 3 + lat, 3 + WL); end
    awaddr = 32'h8000_0044; wdata = 32'h0BAD_BAD0; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if ({bvalid, bresp, awready, wready} !== 5'b10000) begin bad++; $display("FAIL b_stall%0d got=%b exp=10000", i, {bvalid, bresp, awready, wready}); end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    total++; if ({bvalid, awready, wready} !== 3'b011) begin bad++; $display("FAIL b_release got=%b exp=011", {bvalid, awready, wready}); end
    axi_read(32'h8000_0044, d, r, lat);
    total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL stall_no_2nd_write got=%h exp=12345678", d); end
    araddr = 32'h8000_0040; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 40) begin @(negedge clk); lat++; end
    araddr = 32'h8000_0044; arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if ({rvalid, rresp, arready, rdata} !== {4'b1000, 32'hCAFE_F00D}) begin bad++; $display("FAIL r_stall%0d got=%b_%h exp=1000_cafef00d", i, {rvalid, rresp, arready}, rdata); end
    end
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    total++; if ({rvalid, arready} !== 2'b01) begin bad++; $display("FAIL r_release got=%b exp=01", {rvalid, arready}); end
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(32'h8000_0000, 32'hA5A5_A5A5, 4'b1111, lat, r);
    axi_write(32'h8000_3FFC, 32'h5A5A_5A5A, 4'b1111, lat, r);
    total++; if (r !== 2'b00) begin bad++; $display("FAIL top_word_bresp got=%b exp=00", r); end
    axi_read(32'h7FFF_FFFC, d, r, lat);
    total++; if ({r, d} !== {2'b10, 32'h0}) begin bad++; $display("FAIL rd_below got=%b_%h exp=10_00000000", r, d); end
    axi_read(32'h8000_4000, d, r, lat);
    total++; if ({r, d} !== {2'b10, 32'h0}) begin bad++; $display("FAIL rd_above got=%b_%h exp=10_00000000", r, d); end
    axi_write(32'h8000_4000, 32'hFFFF_FFFF, 4'b1111, lat, r);
    total++; if (r !== 2'b10) begin bad++; $display("FAIL wr_above_bresp got=%b exp=10", r); end
    axi_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'b1111, lat, r);
    total++; if (r !== 2'b10) begin bad++; $display("FAIL wr_below_bresp got=%b exp=10", r); end
    axi_read(32'h8000_0000, d, r, lat);
    total++; if ({r, d} !== {2'b00, 32'hA5A5_A5A5}) begin bad++; $display("FAIL word0_kept got=%b_%h exp=00_a5a5a5a5", r, d); end
    axi_read(32'h8000_3FFC, d, r, lat);
    total++; if ({r, d} !== {2'b00, 32'h5A5A_5A5A}) begin bad++; $display("FAIL top_word_kept got=%b_%h exp=00_5a5a5a5a", r, d); end
  endtask

  // AR at edge E0 samples at E0+3; AW/W at E0+1 commits at E0+3.
  task automatic test_collision();
    logic [31:0] d; logic [1:0] r; int lat; int k;
    axi_write(32'h8000_0020, 32'h1111_1111, 4'b1111, lat, r);
    araddr = 32'h8000_0020; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    awaddr = 32'h8000_0020; wdata = 32'h2222_2222; wstrb = 4'b1111; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    k = 0;
    while (!rvalid && k < 40) begin @(negedge clk); k++; end
    total++; if ({k, bvalid} !== {32'd2, 1'b1}) begin bad++; $display("FAIL coll_same_edge got=k%0d_b%b exp=k2_b1", k, bvalid); end
    total++; if (rdata !== 32'h1111_1111) begin bad++; $display("FAIL coll_old_value got=%h exp=11111111", rdata); end
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    axi_read(32'h8000_0020, d, r, lat);
    total++; if (d !== 32'h2222_2222) begin bad++; $display("FAIL coll_new_value got=%h exp=22222222", d); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; logic [1:0] r; int lat; logic seen;
    axi_write(32'h8000_0030, 32'h3333_3333, 4'b1111, lat, r);
    araddr = 32'h8000_0030; awaddr = 32'h8000_0030; wdata = 32'h4444_4444; wstrb = 4'b1111;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++; if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin bad++; $display("FAIL abort_in_reset got=%b exp=00000", {arready, awready, wready, rvalid, bvalid}); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({arready, awready, wready} !== 3'b111) begin bad++; $display("FAIL abort_release got=%b exp=111", {arready, awready, wready}); end
    seen = rvalid | bvalid;
    for (int i = 0; i < 6; i++) begin @(negedge clk); seen |= rvalid | bvalid; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_resp got=%b exp=0", seen); end
    axi_read(32'h8000_0030, d, r, lat);
    total++; if (d !== 32'h3333_3333) begin bad++; $display("FAIL abort_mem_kept got=%h exp=33333333", d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_split_and_stall();
    test_slverr();
    test_collision();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
